lu_row_buffer: RTL and testbench
================================

LU_ROW_BUFFER -- requirements
Module: lu_row_buffer

Interface
REQ-001 SHALL have parameter SIZE, default 32, meaning the matrix dimension (rows, and complex elements per row).
REQ-002 SHALL have parameter WIDTH, default 64, meaning the bits per real or imaginary part (IEEE double).
REQ-003 SHALL define AW = $clog2(SIZE) and RW = SIZE*2*WIDTH; element j of a row occupies bits [j*2*WIDTH +: 2*WIDTH], ordered {imag, real}.
REQ-004 clk_i  in  1  the single clock; all logic SHALL be rising-edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 load_row_i  in  RW  host matrix row.
REQ-007 load_valid_i  in  1  host row valid.
REQ-008 load_ready_o  out  1  buffer can accept a host row.
REQ-009 flush_i  in  1  abort the current matrix and return to LOAD.
REQ-010 start_o  out  1  one-cycle pulse that kicks the LU engine.
REQ-011 rd_addr_i  in  AW  LU row read address.
REQ-012 rd_valid_i  in  1  LU read request.
REQ-013 rd_row_o  out  RW  row data returned to LU.
REQ-014 rd_addr_o  out  AW  address echoed with the returned row.
REQ-015 rd_valid_o  out  1  returned row valid.
REQ-016 wr_row_i  in  RW  LU write-back row.
REQ-017 wr_addr_i  in  AW  write-back address.
REQ-018 wr_valid_i  in  1  write-back valid.
REQ-019 wr_ready_o  out  1  write-back accepted.
REQ-020 done_i  in  1  LU has finished; single-cycle pulse.
REQ-021 busy_o  out  1  high whenever the state is not LOAD.

Function
REQ-022 SHALL implement three states: LOAD, START, SERVE.
REQ-023 LOAD: load_ready_o=1; each load_valid_i&load_ready_o cycle SHALL write load_row_i to row load_cnt and increment load_cnt (AW+1 bits).
REQ-024 On the handshake with load_cnt==SIZE-1, the state SHALL go to START and load_cnt SHALL clear to 0.
REQ-025 START SHALL last exactly one cycle with start_o=1, then go to SERVE; start_o SHALL be 0 in every other state.
REQ-026 SERVE: wr_ready_o=1 and load_ready_o=0; in other states wr_ready_o=0 and writes SHALL be dropped.
REQ-027 Reads in SERVE: a rd_valid_i at cycle N SHALL give rd_valid_o=1, rd_addr_o=rd_addr_i and rd_row_o=row contents at cycle N+1 (latency 1, one request per cycle, no backpressure).
REQ-028 rd_valid_i outside SERVE SHALL be ignored: rd_valid_o=0 on the next cycle.
REQ-029 A read and a write to the same address in the same cycle SHALL return wr_row_i (write-first bypass).
REQ-030 A read one cycle after a write to the same address SHALL return the written data.
REQ-031 An address >= SIZE (non-power-of-2 SIZE only) SHALL read as all zeros, and a write to it SHALL be dropped.
REQ-032 done_i in SERVE SHALL return the state to LOAD with load_cnt=0; done_i in any other state SHALL be ignored.
REQ-033 flush_i in any state SHALL go to LOAD with load_cnt=0 and rd_valid_o=0 next cycle; flush_i has priority over done_i, load and write.
REQ-034 Row storage SHALL NOT be cleared by done_i or flush_i; stale rows are overwritten by the next load.

Reset
REQ-035 Asserting rst_i SHALL immediately force: state=LOAD, load_cnt=0, start_o=0, rd_valid_o=0, rd_addr_o=0, rd_row_o=0, busy_o=0, wr_ready_o=0, load_ready_o=1 after deassertion.
REQ-036 Row storage SHALL NOT require reset; reset mid-SERVE SHALL abandon the operation with no spurious start_o or rd_valid_o.

Verification
REQ-037 Load SIZE=32 rows, row i = element value i+1.0 -> exactly one start_o pulse on the cycle after the 32nd handshake; busy_o=1 from then on.
REQ-038 In SERVE, read addr 5 at cycle N -> rd_valid_o=1, rd_addr_o=5, row of 6.0 at N+1; back-to-back reads 0..31 -> 32 consecutive valid responses.
REQ-039 Same-cycle write of row 7 = 9.5 and read of addr 7 -> response carries 9.5; a later read of addr 7 also returns 9.5.
REQ-040 Load 10 rows, then flush_i -> load_ready_o=1, load_cnt=0; 32 more loads needed before start_o.
REQ-041 done_i in SERVE -> LOAD next cycle; rd_valid_i then gives rd_valid_o=0; wr_valid_i does not change the stored row.
REQ-042 rst_i asserted mid-SERVE between clock edges -> outputs reach their REQ-035 values without waiting for a clock edge.

Source files
------------

// File: rtl/lu_row_buffer.sv
// -----------------------------------------------------------------------------
// lu_row_buffer
//
// Row store that sits between a host and an LU decomposition engine.
// The host streams SIZE rows in (LOAD). The buffer then pulses start_o for one
// cycle (START) and serves row reads and write-backs from the LU engine
// (SERVE) until done_i or flush_i returns it to LOAD.
//
// Each row holds SIZE complex elements. Element j sits at
// [j*2*WIDTH +: 2*WIDTH], ordered {imag, real}.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   load_row_i     host row data (RW bits)
//   load_valid_i   host row valid
//   load_ready_o   buffer accepts a host row (state LOAD)
//   flush_i        abort the current matrix and return to LOAD
//   start_o        one-cycle pulse that kicks the LU engine
//   rd_addr_i      LU read address
//   rd_valid_i     LU read request
//   rd_row_o       returned row, one cycle after the request
//   rd_addr_o      address echoed with the returned row
//   rd_valid_o     returned row valid
//   wr_row_i       LU write-back row
//   wr_addr_i      write-back address
//   wr_valid_i     write-back valid
//   wr_ready_o     write-back accepted (state SERVE)
//   done_i         LU finished, single-cycle pulse
//   busy_o         high whenever the state is not LOAD
// -----------------------------------------------------------------------------
module lu_row_buffer #(
    parameter  int SIZE  = 32,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(SIZE),
    localparam int RW    = SIZE * 2 * WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [RW-1:0] load_row_i,
    input  logic          load_valid_i,
    output logic          load_ready_o,
    input  logic          flush_i,
    output logic          start_o,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_valid_i,
    output logic [RW-1:0] rd_row_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          rd_valid_o,
    input  logic [RW-1:0] wr_row_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic          done_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    localparam logic [AW:0] LAST_CNT = (AW+1)'(SIZE - 1);
    localparam logic [AW:0] SIZE_W   = (AW+1)'(SIZE);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW:0]     load_cnt_r;
    logic [AW:0]     load_cnt_nxt_s;

    logic [RW-1:0]   mem_r [SIZE];
    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [RW-1:0]   mem_wdata_s;

    logic            rd_in_range_s;
    logic            wr_in_range_s;
    logic            rd_accept_s;
    logic            wr_accept_s;
    logic [RW-1:0]   rd_data_s;

    logic            rd_valid_r;
    logic [AW-1:0]   rd_addr_r;
    logic [RW-1:0]   rd_row_r;

    // Addresses at or beyond SIZE only exist when SIZE is not a power of two.
    assign rd_in_range_s = ({1'b0, rd_addr_i} < SIZE_W);
    assign wr_in_range_s = ({1'b0, wr_addr_i} < SIZE_W);

    // flush_i outranks every other action in the cycle it is asserted.
    assign rd_accept_s = (state_r == ST_SERVE) && rd_valid_i && !flush_i;
    assign wr_accept_s = (state_r == ST_SERVE) && wr_valid_i && !flush_i && wr_in_range_s;

    // Status outputs are straight decodes of the state register.
    assign load_ready_o = (state_r == ST_LOAD);
    assign start_o      = (state_r == ST_START);
    assign wr_ready_o   = (state_r == ST_SERVE);
    assign busy_o       = (state_r != ST_LOAD);

    assign rd_valid_o = rd_valid_r;
    assign rd_addr_o  = rd_addr_r;
    assign rd_row_o   = rd_row_r;

    // State register and load counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_LOAD;
            load_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            load_cnt_r <= load_cnt_nxt_s;
        end
    end

    // Next-state and load-counter logic.
    always_comb begin
        state_nxt_s    = state_r;
        load_cnt_nxt_s = load_cnt_r;
        if (flush_i) begin
            state_nxt_s    = ST_LOAD;
            load_cnt_nxt_s = '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (load_valid_i) begin
                        if (load_cnt_r == LAST_CNT) begin
                            state_nxt_s    = ST_START;
                            load_cnt_nxt_s = '0;
                        end else begin
                            load_cnt_nxt_s = load_cnt_r + (AW+1)'(1);
                        end
                    end else begin
                        load_cnt_nxt_s = load_cnt_r;
                    end
                end
                ST_START: begin
                    state_nxt_s = ST_SERVE;
                end
                ST_SERVE: begin
                    if (done_i) begin
                        state_nxt_s    = ST_LOAD;
                        load_cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s = ST_SERVE;
                    end
                end
                default: begin
                    state_nxt_s    = ST_LOAD;
                    load_cnt_nxt_s = '0;
                end
            endcase
        end
    end

    // Select the single row-store write port user: host load or LU write-back.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        if (flush_i) begin
            mem_we_s = 1'b0;
        end else if ((state_r == ST_LOAD) && load_valid_i) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = load_cnt_r[AW-1:0];
            mem_wdata_s = load_row_i;
        end else if (wr_accept_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wr_addr_i;
            mem_wdata_s = wr_row_i;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Row storage; deliberately not reset, rows are overwritten by the next load.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Read data with write-first bypass for a same-cycle write to the same row.
    always_comb begin
        rd_data_s = '0;
        if (!rd_in_range_s) begin
            rd_data_s = '0;
        end else if (wr_accept_s && (wr_addr_i == rd_addr_i)) begin
            rd_data_s = wr_row_i;
        end else begin
            rd_data_s = mem_r[rd_addr_i];
        end
    end

    // Registered read response, latency one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_r <= 1'b0;
            rd_addr_r  <= '0;
            rd_row_r   <= '0;
        end else begin
            rd_valid_r <= rd_accept_s;
            if (rd_accept_s) begin
                rd_addr_r <= rd_addr_i;
                rd_row_r  <= rd_data_s;
            end
        end
    end

endmodule

// File: tb/tb_lu_row_buffer.sv
module tb_lu_row_buffer;

    localparam int SIZE  = 32;
    localparam int WIDTH = 64;
    localparam int AW    = 5;
    localparam int RW    = SIZE * 2 * WIDTH;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [RW-1:0] load_row_i;
    logic          load_valid_i;
    logic          load_ready_o;
    logic          flush_i;
    logic          start_o;
    logic [AW-1:0] rd_addr_i;
    logic          rd_valid_i;
    logic [RW-1:0] rd_row_o;
    logic [AW-1:0] rd_addr_o;
    logic          rd_valid_o;
    logic [RW-1:0] wr_row_i;
    logic [AW-1:0] wr_addr_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic          done_i;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    lu_row_buffer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_row_i   (load_row_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .flush_i      (flush_i),
        .start_o      (start_o),
        .rd_addr_i    (rd_addr_i),
        .rd_valid_i   (rd_valid_i),
        .rd_row_o     (rd_row_o),
        .rd_addr_o    (rd_addr_o),
        .rd_valid_o   (rd_valid_o),
        .wr_row_i     (wr_row_i),
        .wr_addr_i    (wr_addr_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .done_i       (done_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Every element of the row carries real part v and imaginary part 0.
    function automatic logic [RW-1:0] make_row(input real v);
        logic [RW-1:0] r;
        r = '0;
        for (int j = 0; j < SIZE; j++) begin
            r[j*2*WIDTH +: 2*WIDTH] = {64'h0, $realtobits(v)};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_rows(input int n, input real base, input bit expect_start);
        logic exp_start;
        for (int i = 0; i < n; i++) begin
            load_row_i   = make_row(base + i);
            load_valid_i = 1'b1;
            tick();
            exp_start = expect_start && (i == n - 1);
            checks++;
            if (start_o !== exp_start) begin
                errors++;
                $display("FAIL load_start row %0d: start_o=%b expected %b", i, start_o, exp_start);
            end
        end
        load_valid_i = 1'b0;
    endtask

    task automatic read_row(input int addr, input real v, input string tag);
        logic [RW-1:0] exp_row;
        exp_row    = make_row(v);
        rd_addr_i  = AW'(addr);
        rd_valid_i = 1'b1;
        tick();
        rd_valid_i = 1'b0;
        checks++;
        if (rd_valid_o !== 1'b1 || rd_addr_o !== AW'(addr)) begin
            errors++;
            $display("FAIL %s valid/addr: got %b/%0d expected 1/%0d", tag, rd_valid_o, rd_addr_o, addr);
        end
        checks++;
        if (rd_row_o !== exp_row) begin
            errors++;
            $display("FAIL %s row: got elem0=%h top=%h expected elem0=%h top=%h", tag,
                     rd_row_o[63:0], rd_row_o[RW-1 -: 64], exp_row[63:0], exp_row[RW-1 -: 64]);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        load_row_i = '0; load_valid_i = 1'b0; flush_i = 1'b0;
        rd_addr_i = '0; rd_valid_i = 1'b0; wr_row_i = '0; wr_addr_i = '0;
        wr_valid_i = 1'b0; done_i = 1'b0;
        #12;
        checks++;
        if ({start_o, rd_valid_o, busy_o, wr_ready_o, load_ready_o} !== 5'b00001 ||
            rd_addr_o !== 5'd0 || rd_row_o !== '0) begin
            errors++;
            $display("FAIL reset_state: start/rdv/busy/wrr/ldr=%b%b%b%b%b expected 00001",
                     start_o, rd_valid_o, busy_o, wr_ready_o, load_ready_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        checks++;
        if (load_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: load_ready=%b busy=%b expected 1 0", load_ready_o, busy_o);
        end
    endtask

    task automatic test_load();
        load_rows(SIZE, 1.0, 1'b1);
        checks++;
        if (busy_o !== 1'b1 || load_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL start_state: busy=%b load_ready=%b expected 1 0", busy_o, load_ready_o);
        end
        tick();
        checks++;
        if (start_o !== 1'b0 || busy_o !== 1'b1 || wr_ready_o !== 1'b1 || load_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL serve_entry: start=%b busy=%b wr_ready=%b load_ready=%b expected 0 1 1 0",
                     start_o, busy_o, wr_ready_o, load_ready_o);
        end
    endtask

    task automatic test_read();
        int valid_cnt;
        read_row(5, 6.0, "read_addr5");
        valid_cnt = 0;
        for (int i = 0; i < SIZE; i++) begin
            rd_addr_i  = AW'(i);
            rd_valid_i = 1'b1;
            tick();
            if (rd_valid_o === 1'b1 && rd_addr_o === AW'(i) && rd_row_o === make_row(i + 1.0))
                valid_cnt++;
        end
        rd_valid_i = 1'b0;
        checks++;
        if (valid_cnt != SIZE) begin
            errors++;
            $display("FAIL back_to_back: %0d correct responses, expected %0d", valid_cnt, SIZE);
        end
        tick();
        checks++;
        if (rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: rd_valid_o=%b expected 0", rd_valid_o);
        end
    endtask

    task automatic test_bypass();
        wr_addr_i  = 5'd7;
        wr_row_i   = make_row(9.5);
        wr_valid_i = 1'b1;
        read_row(7, 9.5, "same_cycle_bypass");
        wr_valid_i = 1'b0;
        read_row(7, 9.5, "read_after_bypass");
        wr_addr_i  = 5'd8;
        wr_row_i   = make_row(2.25);
        wr_valid_i = 1'b1;
        tick();
        wr_valid_i = 1'b0;
        read_row(8, 2.25, "read_next_cycle");
        read_row(6, 7.0, "neighbour_row");
    endtask

    task automatic test_done();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || load_ready_o !== 1'b1 || wr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL done_to_load: busy=%b load_ready=%b wr_ready=%b expected 0 1 0",
                     busy_o, load_ready_o, wr_ready_o);
        end
        rd_addr_i  = 5'd3;
        rd_valid_i = 1'b1;
        tick();
        rd_valid_i = 1'b0;
        checks++;
        if (rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL read_in_load: rd_valid_o=%b expected 0", rd_valid_o);
        end
        // Junk write-back held during the whole reload must never reach row 0.
        wr_addr_i  = 5'd0;
        wr_row_i   = make_row(-1.0);
        wr_valid_i = 1'b1;
        load_rows(SIZE, 101.0, 1'b1);
        wr_valid_i = 1'b0;
        tick();
        read_row(0, 101.0, "write_dropped_in_load");
        read_row(31, 132.0, "reload_last_row");
    endtask

    task automatic test_flush();
        flush_i = 1'b1; done_i = 1'b1;
        rd_addr_i = 5'd2; rd_valid_i = 1'b1;
        wr_addr_i = 5'd2; wr_row_i = make_row(-2.0); wr_valid_i = 1'b1;
        tick();
        flush_i = 1'b0; done_i = 1'b0; rd_valid_i = 1'b0; wr_valid_i = 1'b0;
        checks++;
        if (rd_valid_o !== 1'b0 || busy_o !== 1'b0 || load_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_serve: rd_valid=%b busy=%b load_ready=%b expected 0 0 1",
                     rd_valid_o, busy_o, load_ready_o);
        end
        load_rows(10, 301.0, 1'b0);
        flush_i      = 1'b1;
        load_row_i   = make_row(-3.0);
        load_valid_i = 1'b1;
        tick();
        flush_i = 1'b0; load_valid_i = 1'b0;
        checks++;
        if (load_ready_o !== 1'b1 || busy_o !== 1'b0 || start_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_load: load_ready=%b busy=%b start=%b expected 1 0 0",
                     load_ready_o, busy_o, start_o);
        end
        load_rows(SIZE, 201.0, 1'b1);
        tick();
        read_row(2, 203.0, "after_flush_row2");
        read_row(9, 210.0, "after_flush_row9");
        read_row(10, 211.0, "after_flush_row10");
    endtask

    task automatic test_reset_mid_serve();
        rd_addr_i  = 5'd4;
        rd_valid_i = 1'b1;
        tick();
        checks++;
        if (rd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_read: rd_valid_o=%b expected 1", rd_valid_o);
        end
        #3;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({start_o, rd_valid_o, busy_o, wr_ready_o, load_ready_o} !== 5'b00001 ||
            rd_addr_o !== 5'd0 || rd_row_o !== '0) begin
            errors++;
            $display("FAIL async_reset: start/rdv/busy/wrr/ldr=%b%b%b%b%b addr=%0d expected 00001 0",
                     start_o, rd_valid_o, busy_o, wr_ready_o, load_ready_o, rd_addr_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (start_o !== 1'b0 || rd_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL after_reset cycle %0d: start=%b rd_valid=%b busy=%b expected 0 0 0",
                         i, start_o, rd_valid_o, busy_o);
            end
        end
        rd_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_read();
        test_bypass();
        test_done();
        test_flush();
        test_reset_mid_serve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
